fifo_top: RTL and testbench

- Synchronous first-word-fall-through FIFO: 2^ASIZE entries, each DSIZE bits wide.
- Write side and read side share one clock, wclk.
- Sits between a producer and a consumer in the same clock domain and gives registered full and empty status.
- Pointers are (ASIZE+1)-bit binary counters, each with a Gray-coded copy kept for status comparison and debug visibility.

---
 rtl/fifo_top.sv | 83 ++++++++
 tb/tb_fifo_top.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_top.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Binary pointers address the memory; Gray copies drive the flag comparison.
module fifo_top #(
  parameter int DSIZE = 6,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_r [DEPTH];
  logic [ASIZE:0]   wbin_r, rbin_r, wgray_r, rgray_r;
  logic [ASIZE:0]   wbin_next_s, rbin_next_s, wgray_next_s, rgray_next_s;
  logic             wfull_r, rempty_r;
  logic             we_s, re_s, full_next_s, empty_next_s;

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next-state pointers and flags; flags look ahead so they carry no extra latency
  always_comb begin
    we_s = winc & ~wfull_r;
    re_s = rinc & ~rempty_r;
    if (we_s) begin
      wbin_next_s  = wbin_r + {{ASIZE{1'b0}}, 1'b1};
      wgray_next_s = bin2gray(wbin_r + {{ASIZE{1'b0}}, 1'b1});
    end else begin
      wbin_next_s  = wbin_r;
      wgray_next_s = wgray_r;
    end
    if (re_s) begin
      rbin_next_s  = rbin_r + {{ASIZE{1'b0}}, 1'b1};
      rgray_next_s = bin2gray(rbin_r + {{ASIZE{1'b0}}, 1'b1});
    end else begin
      rbin_next_s  = rbin_r;
      rgray_next_s = rgray_r;
    end
    empty_next_s = (rgray_next_s == wgray_next_s);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted
    full_next_s  = (wgray_next_s ==
                    {~rgray_next_s[ASIZE:ASIZE-1], rgray_next_s[ASIZE-2:0]});
  end

  // Pointer and flag registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r   <= {(ASIZE+1){1'b0}};
      rbin_r   <= {(ASIZE+1){1'b0}};
      wgray_r  <= {(ASIZE+1){1'b0}};
      rgray_r  <= {(ASIZE+1){1'b0}};
      wfull_r  <= 1'b0;
      rempty_r <= 1'b1;
    end else begin
      wbin_r   <= wbin_next_s;
      rbin_r   <= rbin_next_s;
      wgray_r  <= wgray_next_s;
      rgray_r  <= rgray_next_s;
      wfull_r  <= full_next_s;
      rempty_r <= empty_next_s;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge wclk) begin
    if (we_s) begin
      mem_r[wbin_r[ASIZE-1:0]] <= wdata;
    end
  end

  assign rdata  = mem_r[rbin_r[ASIZE-1:0]];
  assign wfull  = wfull_r;
  assign rempty = rempty_r;

endmodule

// File: tb/tb_fifo_top.sv
// Directed self-checking bench for fifo_top: reset, fill/drain, simultaneous
// access, wrap-around and asynchronous mid-operation reset.
module tb_fifo_top;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [5:0] wdata;
  logic       rinc;
  logic [5:0] rdata;
  logic       wfull;
  logic       rempty;

  int         n_cmp;
  int         n_err;
  logic [5:0] exp_q [$];

  fifo_top #(.DSIZE(6), .ASIZE(4)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .winc  (winc),
    .wdata (wdata),
    .rinc  (rinc),
    .rdata (rdata),
    .wfull (wfull),
    .rempty(rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] dval(input int i);
    return 6'((i * 7 + 5) % 64);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: observed empty model expected entry", tag);
    end else begin
      check_data(tag, rdata, exp_q[0]);
    end
  endtask

  // One clock: drive requests, take the edge, sample 1 ns later
  task automatic step(input logic w, input logic r, input logic [5:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge wclk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  initial begin
    logic r_s;
    int   occ;
    n_cmp  = 0;
    n_err  = 0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 6'h00;
    wrst_n = 1'b1;

    // Reset with toggling requests
    #1 wrst_n = 1'b0;
    #1;
    check_bit("rst_empty_async", rempty, 1'b1);
    check_bit("rst_full_async", wfull, 1'b0);
    for (int i = 0; i < 4; i++) begin
      winc  = ~winc;
      rinc  = ~rinc;
      wdata = dval(i);
      #5;
      check_bit("rst_empty", rempty, 1'b1);
      check_bit("rst_full", wfull, 1'b0);
    end
    winc   = 1'b0;
    rinc   = 1'b0;
    wrst_n = 1'b1;

    // Fill with 17 writes; the 17th is dropped
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, dval(i));
      check_bit("fill_full", wfull, (i >= 15));
      check_bit("fill_empty", rempty, 1'b0);
      if (i == 0) check_data("fwft_first", rdata, dval(0));
    end
    check_data("fill_head", rdata, dval(0));

    // Drain 16, then one blocked read
    for (int i = 0; i < 16; i++) begin
      check_data("drain_data", rdata, dval(i));
      step(1'b0, 1'b1, 6'h00);
      check_bit("drain_empty", rempty, (i == 15));
      check_bit("drain_full", wfull, 1'b0);
    end
    step(1'b0, 1'b1, 6'h00);
    check_bit("underflow_empty", rempty, 1'b1);
    check_bit("underflow_full", wfull, 1'b0);

    // Simultaneous request while empty: only the push happens
    step(1'b1, 1'b1, 6'h2A);
    check_bit("empty_rw_empty", rempty, 1'b0);
    check_data("empty_rw_data", rdata, 6'h2A);
    exp_q.push_back(6'h2A);

    // Build 5 entries then 10 cycles of simultaneous push/pop
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, dval(20 + i));
      exp_q.push_back(dval(20 + i));
    end
    for (int k = 0; k < 10; k++) begin
      check_head("sim_head");
      step(1'b1, 1'b1, dval(30 + k));
      void'(exp_q.pop_front());
      exp_q.push_back(dval(30 + k));
      check_bit("sim_empty", rempty, 1'b0);
      check_bit("sim_full", wfull, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      check_head("sim_drain");
      step(1'b0, 1'b1, 6'h00);
      void'(exp_q.pop_front());
    end
    check_bit("sim_drained", rempty, 1'b1);

    // Fill to full, then simultaneous request: only the pop happens
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, dval(50 + i));
      exp_q.push_back(dval(50 + i));
    end
    check_bit("full_set", wfull, 1'b1);
    check_head("full_rw_head");
    step(1'b1, 1'b1, 6'h3F);
    void'(exp_q.pop_front());
    check_bit("full_rw_full", wfull, 1'b0);
    check_bit("full_rw_empty", rempty, 1'b0);
    for (int i = 0; i < 15; i++) begin
      check_head("full_drain");
      step(1'b0, 1'b1, 6'h00);
      void'(exp_q.pop_front());
      check_bit("full_drain_empty", rempty, (exp_q.size() == 0));
    end

    // Wrap-around: 40 writes with reads keeping occupancy in 1..10
    occ = 0;
    for (int k = 0; k < 40; k++) begin
      r_s = (occ >= 2) && ((k % 2 == 1) || (occ >= 10));
      if (r_s) check_head("wrap_head");
      step(1'b1, r_s, dval(100 + k));
      exp_q.push_back(dval(100 + k));
      if (r_s) void'(exp_q.pop_front());
      occ = occ + 1 - (r_s ? 1 : 0);
      check_bit("wrap_full", wfull, 1'b0);
      check_bit("wrap_empty", rempty, 1'b0);
    end
    while (exp_q.size() > 0) begin
      check_head("wrap_drain");
      step(1'b0, 1'b1, 6'h00);
      void'(exp_q.pop_front());
      check_bit("wrap_drain_empty", rempty, (exp_q.size() == 0));
    end

    // Mid-operation asynchronous reset with 9 entries
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, dval(200 + i));
    end
    check_bit("pre_rst_empty", rempty, 1'b0);
    #3 wrst_n = 1'b0;
    #1;
    check_bit("mid_rst_empty", rempty, 1'b1);
    check_bit("mid_rst_full", wfull, 1'b0);
    #2 wrst_n = 1'b1;
    step(1'b1, 1'b0, 6'h15);
    check_bit("post_rst_empty", rempty, 1'b0);
    check_data("post_rst_data", rdata, 6'h15);
    step(1'b0, 1'b1, 6'h00);
    check_bit("post_rst_drain", rempty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
